// File: rtl/safelock_pkg.sv
// safelock_pkg: shared state encoding and code defaults
// for the lock controller slice.
package safelock_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  localparam int DEF_PW_WIDTH = 12;

  localparam logic [DEF_PW_WIDTH-1:0] DEF_PW = 12'h123;

endpackage

// File: rtl/safelock_if.sv
// safelock_if: entry-block side requests and lock
// indicators between the entry path and the controller.
interface safelock_if
  import safelock_pkg::*;
#(
  parameter int PW_WIDTH = DEF_PW_WIDTH,
  parameter int AW       = 2
);

  logic [PW_WIDTH-1:0] i_password;
  logic                i_check;
  logic                i_set_new;
  logic                i_close;
  logic                o_unlocked;
  logic                o_alarm;
  logic                o_error;
  logic                o_clear_entry;
  logic [AW-1:0]       o_attempts_left;

  modport master (
    output i_password,
    output i_check,
    output i_set_new,
    output i_close,
    input  o_unlocked,
    input  o_alarm,
    input  o_error,
    input  o_clear_entry,
    input  o_attempts_left
  );

  modport slave (
    input  i_password,
    input  i_check,
    input  i_set_new,
    input  i_close,
    output o_unlocked,
    output o_alarm,
    output o_error,
    output o_clear_entry,
    output o_attempts_left
  );

endinterface

// File: rtl/safelock_timer.sv
// safelock_timer: loadable down-counter that parks at
// zero; shared by the OPEN and LOCKOUT intervals.
module safelock_timer #(
  parameter int W = 13
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/safelock_controller.sv
// safelock_controller: code check, failed-attempt count,
// timed lockout and auto-relock with registered outputs.
module safelock_controller
  import safelock_pkg::*;
#(
  parameter int                  PW_WIDTH       = DEF_PW_WIDTH,
  parameter logic [PW_WIDTH-1:0] DEFAULT_PW     = DEF_PW,
  parameter int                  MAX_ATTEMPTS   = 3,
  parameter int                  LOCKOUT_CYCLES = 1000,
  parameter int                  OPEN_CYCLES    = 5000
) (
  input logic i_clk,
  input logic i_reset_n,
  safelock_if.slave bus
);

  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int TMAX = (LOCKOUT_CYCLES > OPEN_CYCLES)
                      ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int TW = $clog2(TMAX);
  localparam logic [AW-1:0] MAX_C = AW'(MAX_ATTEMPTS);
  localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [PW_WIDTH-1:0] pw_q, pw_d;
  logic [AW-1:0]       fail_q, fail_d;
  logic [AW-1:0]       fail_inc;
  logic                unl_q, unl_d;
  logic                alarm_q, alarm_d;
  logic                err_q, err_d;
  logic                clr_q, clr_d;
  logic [AW-1:0]       att_q, att_d;
  logic                ld;
  logic [TW-1:0]       ld_val;
  logic                tmr_zero;

  safelock_timer #(
    .W(TW)
  ) u_timer (
    .clk_i      (i_clk),
    .rst_ni     (i_reset_n),
    .load_i     (ld),
    .load_val_i (ld_val),
    .zero_o     (tmr_zero)
  );

  assign fail_inc = fail_q + AW'(1);

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    fail_d  = fail_q;
    err_d   = 1'b0;
    clr_d   = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (1'b1)
      (state_q == ST_LOCKED): begin
        if (bus.i_check) begin
          clr_d = 1'b1;
          if (bus.i_password == pw_q) begin
            state_d = ST_OPEN;
            fail_d  = '0;
            ld      = 1'b1;
            ld_val  = OPEN_LD;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_inc;
            if (fail_inc == MAX_C) begin
              state_d = ST_LOCKOUT;
              ld      = 1'b1;
              ld_val  = LOCK_LD;
            end
          end
        end
      end
      (state_q == ST_OPEN): begin
        // A store on the timeout cycle reloads and keeps it open.
        if (bus.i_set_new) begin
          pw_d   = bus.i_password;
          clr_d  = 1'b1;
          ld     = 1'b1;
          ld_val = OPEN_LD;
        end
        if (bus.i_close) begin
          state_d = ST_LOCKED;
        end else if (tmr_zero && !bus.i_set_new) begin
          state_d = ST_LOCKED;
        end
      end
      (state_q == ST_LOCKOUT): begin
        if (tmr_zero) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end
      end
      default: begin
        state_d = ST_LOCKED;
        fail_d  = '0;
      end
    endcase
    unl_d   = (state_d == ST_OPEN);
    alarm_d = (state_d == ST_LOCKOUT);
    att_d   = alarm_d ? '0 : (MAX_C - fail_d);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_LOCKED;
      pw_q    <= DEFAULT_PW;
      fail_q  <= '0;
      unl_q   <= 1'b0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      att_q   <= MAX_C;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      fail_q  <= fail_d;
      unl_q   <= unl_d;
      alarm_q <= alarm_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
      att_q   <= att_d;
    end
  end

  assign bus.o_unlocked      = unl_q;
  assign bus.o_alarm         = alarm_q;
  assign bus.o_error         = err_q;
  assign bus.o_clear_entry   = clr_q;
  assign bus.o_attempts_left = att_q;

endmodule

// File: tb/tb_safelock_controller.sv
// tb_safelock_controller: deadline-based reference model,
// directed scenarios and randomized traffic.
module tb_safelock_controller;

  localparam int MAXA = 3;
  localparam int LCK  = 37;
  localparam int OPN  = 53;
  localparam int AW   = $clog2(MAXA + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  safelock_if #(.PW_WIDTH(12), .AW(AW)) bus ();

  safelock_controller #(
    .PW_WIDTH       (12),
    .DEFAULT_PW     (12'h123),
    .MAX_ATTEMPTS   (MAXA),
    .LOCKOUT_CYCLES (LCK),
    .OPEN_CYCLES    (OPN)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: intervals tracked as absolute edge deadlines.
  longint      n       = 0;
  longint      dl      = 0;
  bit          m_open  = 1'b0;
  bit          m_lock  = 1'b0;
  logic [11:0] m_code  = 12'h123;
  int          m_fails = 0;
  bit          e_err   = 1'b0;
  bit          e_clr   = 1'b0;
  bit          tout;

  always @(posedge clk) begin
    n++;
    e_err = 1'b0;
    e_clr = 1'b0;
    if (!rst_n) begin
      m_open  = 1'b0;
      m_lock  = 1'b0;
      m_code  = 12'h123;
      m_fails = 0;
    end else if (m_lock) begin
      if (n == dl) begin
        m_lock  = 1'b0;
        m_fails = 0;
      end
    end else if (m_open) begin
      tout = (n == dl);
      if (bus.i_set_new) begin
        m_code = bus.i_password;
        e_clr  = 1'b1;
        dl     = n + OPN;
      end
      if (bus.i_close || (tout && !bus.i_set_new)) m_open = 1'b0;
    end else if (bus.i_check) begin
      e_clr = 1'b1;
      if (bus.i_password == m_code) begin
        m_open  = 1'b1;
        m_fails = 0;
        dl      = n + OPN;
      end else begin
        e_err = 1'b1;
        m_fails++;
        if (m_fails >= MAXA) begin
          m_lock = 1'b1;
          dl     = n + LCK;
        end
      end
    end
    #1;
    chk("unlocked", bus.o_unlocked, m_open);
    chk("alarm", bus.o_alarm, m_lock);
    chk("error", bus.o_error, e_err);
    chk("clear_entry", bus.o_clear_entry, e_clr);
    chk("attempts_left", bus.o_attempts_left,
        m_lock ? 0 : MAXA - m_fails);
  end

  task automatic step(input bit c, input bit s, input bit cl,
                      input logic [11:0] pw);
    @(negedge clk);
    bus.i_check    = c;
    bus.i_set_new  = s;
    bus.i_close    = cl;
    bus.i_password = pw;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic smp();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int r;
    logic [11:0] pw;
    logic [11:0] one;
    one = 12'h001;
    bus.i_check    = 1'b0;
    bus.i_set_new  = 1'b0;
    bus.i_close    = 1'b0;
    bus.i_password = 12'h000;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_unlocked", bus.o_unlocked, 0);
    chk("rst_alarm", bus.o_alarm, 0);
    chk("rst_attempts", bus.o_attempts_left, 3);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 0, 0, 12'h123);
    smp();
    chk("open_unlocked", bus.o_unlocked, 1);
    chk("open_clear", bus.o_clear_entry, 1);
    chk("open_attempts", bus.o_attempts_left, 3);
    idle();
    smp();
    chk("clear_one_cycle", bus.o_clear_entry, 0);
    step(0, 0, 1, 12'h000);
    smp();
    chk("close_relock", bus.o_unlocked, 0);

    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 12'h456);
      smp();
      chk("wrong_error", bus.o_error, 1);
      chk("wrong_attempts", bus.o_attempts_left, 2 - k);
    end
    chk("lockout_alarm", bus.o_alarm, 1);
    cnt = 1;
    for (int k = 0; k < 4 * LCK; k++) begin
      step(k == 5, 0, 0, (k == 5) ? 12'h123 : 12'h000);
      smp();
      if (k == 5) begin
        chk("lock_ign_unl", bus.o_unlocked, 0);
        chk("lock_ign_err", bus.o_error, 0);
        chk("lock_ign_clr", bus.o_clear_entry, 0);
      end
      if (bus.o_alarm) cnt++;
      else break;
    end
    chk("lockout_len", cnt, LCK);
    chk("post_lock_attempts", bus.o_attempts_left, 3);

    step(1, 0, 0, 12'h123);
    smp();
    step(0, 1, 0, 12'h789);
    smp();
    chk("setnew_clear", bus.o_clear_entry, 1);
    chk("setnew_open", bus.o_unlocked, 1);
    step(0, 0, 1, 12'h000);
    smp();
    step(1, 0, 0, 12'h123);
    smp();
    chk("old_code_error", bus.o_error, 1);
    step(1, 0, 0, 12'h789);
    smp();
    chk("new_code_unlock", bus.o_unlocked, 1);

    cnt = 1;
    for (int k = 0; k < 4 * OPN; k++) begin
      idle();
      smp();
      if (bus.o_unlocked) cnt++;
      else break;
    end
    chk("open_timeout_len", cnt, OPN);

    step(1, 0, 0, 12'h789);
    smp();
    for (int k = 0; k < OPN - 1; k++) begin
      idle();
      smp();
    end
    step(0, 1, 0, 12'h789);
    smp();
    chk("reload_open", bus.o_unlocked, 1);
    cnt = 1;
    for (int k = 0; k < 4 * OPN; k++) begin
      idle();
      smp();
      if (bus.o_unlocked) cnt++;
      else break;
    end
    chk("reload_len", cnt, OPN);

    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 12'h123);
      smp();
    end
    repeat (4) begin
      idle();
      smp();
    end
    chk("pre_rst_alarm", bus.o_alarm, 1);
    @(negedge clk);
    rst_n = 1'b0;
    smp();
    chk("mid_rst_alarm", bus.o_alarm, 0);
    chk("mid_rst_attempts", bus.o_attempts_left, 3);
    rst_n = 1'b1;
    step(1, 0, 0, 12'h123);
    smp();
    chk("rst_default_code", bus.o_unlocked, 1);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 499) != 0);
      r = $urandom_range(0, 5);
      case (r)
        0, 1:    pw = m_code;
        2:       pw = 12'h123;
        3:       pw = m_code ^ (one << $urandom_range(0, 11));
        default: pw = 12'($urandom);
      endcase
      bus.i_password = pw;
      bus.i_check    = ($urandom_range(0, 3) == 0);
      bus.i_set_new  = ($urandom_range(0, 9) == 0);
      bus.i_close    = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    smp();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
